// File: rtl/gtx_frame_pkg.sv
// Shared constants and state encoding for the GTX transmit framer.
package gtx_frame_pkg;

  localparam logic [15:0] K_IDLE = 16'h02BC;
  localparam logic [1:0]  CTRL_K = 2'b01;
  localparam logic [1:0]  CTRL_D = 2'b00;

  localparam logic [15:0] HDR0  = 16'h2410;
  localparam logic [15:0] HDR1  = 16'h1984;
  localparam logic [15:0] TAIL0 = 16'hDBEF;
  localparam logic [15:0] TAIL1 = 16'hE67B;

  localparam logic [15:0] TYPE_CFG  = 16'h0001;
  localparam logic [15:0] TYPE_ACK  = 16'h0002;
  localparam logic [15:0] TYPE_DATA = 16'h0003;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StHdr,
    StPay,
    StCsum,
    StTail,
    StIfg
  } frame_state_e;

endpackage

// File: rtl/gtx_frame_rr_sel.sv
// Two-port selector: port 0 by default, port 1 when alone or after MAX_CONSEC
// back-to-back port-0 grants made while port 1 was waiting.
module gtx_frame_rr_sel #(
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       grant
);

  localparam int unsigned CW = $clog2(MAX_CONSEC + 1);

  logic [CW-1:0] consec_q, consec_d;

  assign grant = (req == 2'b10) || (req[1] && (consec_q == CW'(MAX_CONSEC)));

  always_comb begin
    consec_d = consec_q;
    if (grant_en) begin
      if (grant) begin
        consec_d = '0;
      end else if (req[1]) begin
        consec_d = consec_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      consec_q <= '0;
    end else begin
      consec_q <= consec_d;
    end
  end

endmodule

// File: rtl/gtx_tx_frame_arbiter.sv
// Shares the 16-bit GTX transmit lane between a control port (0) and a data port (1),
// framing the winner as header/seq/type/len/payload/checksum/tail with K idles between.
module gtx_tx_frame_arbiter
  import gtx_frame_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS = 24,
  parameter int unsigned IFG_WORDS     = 4,
  parameter int unsigned PRE_WORDS     = 2,
  parameter int unsigned MAX_CONSEC    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_up,
  input  logic [1:0]  req,
  input  logic [15:0] req_type0,
  input  logic [15:0] req_type1,
  output logic [4:0]  pl_addr,
  output logic        pl_sel,
  input  logic [15:0] pl_data0,
  input  logic [15:0] pl_data1,
  output logic [1:0]  done,
  output logic        abort,
  output logic [15:0] seq_num,
  output logic [15:0] TX_DATA,
  output logic [1:0]  TXCTRL
);

  localparam logic [4:0]  PL_LAST  = 5'(PAYLOAD_WORDS - 1);
  localparam logic [15:0] LEN_WORD = 16'(PAYLOAD_WORDS);
  localparam logic [7:0]  PRE_LAST = 8'(PRE_WORDS - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_WORDS - 1);

  frame_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [4:0]   pl_addr_q, pl_addr_d;
  logic         pl_sel_q, pl_sel_d;
  logic [15:0]  tx_data_q, tx_data_d;
  logic [1:0]   txctrl_q, txctrl_d;
  logic [15:0]  csum_q, csum_d;
  logic [15:0]  seq_q, seq_d;
  logic [1:0]   done_q, done_d;
  logic         abort_q, abort_d;
  logic         grant_en;
  logic         grant;
  logic [15:0]  pl_word;
  logic [15:0]  type_word;
  logic [15:0]  hdr_word;
  logic         in_frame;

  gtx_frame_rr_sel #(
    .MAX_CONSEC(MAX_CONSEC)
  ) u_rr_sel (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant_en (grant_en),
    .grant    (grant)
  );

  assign pl_word   = pl_sel_q ? pl_data1 : pl_data0;
  assign type_word = pl_sel_q ? req_type1 : req_type0;
  assign in_frame  = (state_q == StPre) || (state_q == StHdr) || (state_q == StPay) ||
                     (state_q == StCsum) || (state_q == StTail);

  always_comb begin
    unique case (cnt_q)
      8'd0:    hdr_word = HDR0;
      8'd1:    hdr_word = HDR1;
      8'd2:    hdr_word = seq_q;
      8'd3:    hdr_word = type_word;
      default: hdr_word = LEN_WORD;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pl_addr_d = 5'd0;
    pl_sel_d  = pl_sel_q;
    tx_data_d = K_IDLE;
    txctrl_d  = CTRL_K;
    csum_d    = csum_q;
    seq_d     = seq_q;
    done_d    = 2'b00;
    abort_d   = 1'b0;
    grant_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (link_up && (req != 2'b00)) begin
          grant_en = 1'b1;
          pl_sel_d = grant;
          cnt_d    = 8'd0;
          csum_d   = 16'd0;
          state_d  = StPre;
        end
      end
      StPre: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = 8'd0;
          state_d = StHdr;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHdr: begin
        tx_data_d = hdr_word;
        txctrl_d  = CTRL_D;
        // Checksum covers seq, type and length, not the sync header.
        if (cnt_q >= 8'd2) csum_d = csum_q + hdr_word;
        if (cnt_q == 8'd4) begin
          cnt_d   = 8'd0;
          state_d = StPay;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StPay: begin
        tx_data_d = pl_word;
        txctrl_d  = CTRL_D;
        csum_d    = csum_q + pl_word;
        if (pl_addr_q == PL_LAST) begin
          state_d = StCsum;
        end else begin
          pl_addr_d = pl_addr_q + 5'd1;
        end
      end
      StCsum: begin
        tx_data_d = csum_q;
        txctrl_d  = CTRL_D;
        cnt_d     = 8'd0;
        state_d   = StTail;
      end
      StTail: begin
        txctrl_d = CTRL_D;
        if (cnt_q == 8'd0) begin
          tx_data_d = TAIL0;
          cnt_d     = 8'd1;
        end else begin
          tx_data_d = TAIL1;
          done_d    = pl_sel_q ? 2'b10 : 2'b01;
          seq_d     = seq_q + 16'd1;
          cnt_d     = 8'd0;
          state_d   = StIfg;
        end
      end
      StIfg: begin
        if (cnt_q == IFG_LAST) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
    endcase

    // Lane loss cuts the frame; the request stays up so it is retried from scratch.
    if (!link_up && in_frame) begin
      tx_data_d = K_IDLE;
      txctrl_d  = CTRL_K;
      csum_d    = csum_q;
      seq_d     = seq_q;
      done_d    = 2'b00;
      abort_d   = 1'b1;
      pl_addr_d = 5'd0;
      cnt_d     = 8'd0;
      state_d   = StIfg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      pl_addr_q <= 5'd0;
      pl_sel_q  <= 1'b0;
      tx_data_q <= K_IDLE;
      txctrl_q  <= CTRL_K;
      csum_q    <= 16'd0;
      seq_q     <= 16'd0;
      done_q    <= 2'b00;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pl_addr_q <= pl_addr_d;
      pl_sel_q  <= pl_sel_d;
      tx_data_q <= tx_data_d;
      txctrl_q  <= txctrl_d;
      csum_q    <= csum_d;
      seq_q     <= seq_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign pl_addr = pl_addr_q;
  assign pl_sel  = pl_sel_q;
  assign done    = done_q;
  assign abort   = abort_q;
  assign seq_num = seq_q;
  assign TX_DATA = tx_data_q;
  assign TXCTRL  = txctrl_q;

endmodule

// File: tb/tb_gtx_tx_frame_arbiter.sv
// Directed bench for gtx_tx_frame_arbiter: framing, checksum, arbitration order,
// link loss retry, sequence wrap and mid-frame reset.
module tb_gtx_tx_frame_arbiter;
  import gtx_frame_pkg::*;

  localparam int unsigned PW  = 24;
  localparam int unsigned IFG = 4;
  localparam int unsigned PRE = 2;
  localparam int unsigned MC  = 4;
  localparam int FW = PW + 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_up;
  logic [1:0]  req;
  logic [15:0] req_type0, req_type1;
  logic [4:0]  pl_addr;
  logic        pl_sel;
  logic [15:0] pl_data0, pl_data1;
  logic [1:0]  done;
  logic        abort;
  logic [15:0] seq_num;
  logic [15:0] TX_DATA;
  logic [1:0]  TXCTRL;

  logic [15:0] pay0 [32];
  logic [15:0] pay1 [32];
  logic [15:0] fw [FW];
  logic [15:0] ew [FW];
  logic [1:0]  done_or;
  logic        ctrl_ok;
  logic [15:0] exp_seq;
  int n_vec = 0;
  int n_err = 0;
  int k_run = 0;

  always #5 clk = ~clk;

  assign pl_data0 = pay0[pl_addr];
  assign pl_data1 = pay1[pl_addr];

  gtx_tx_frame_arbiter #(
    .PAYLOAD_WORDS(PW),
    .IFG_WORDS    (IFG),
    .PRE_WORDS    (PRE),
    .MAX_CONSEC   (MC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .link_up   (link_up),
    .req       (req),
    .req_type0 (req_type0),
    .req_type1 (req_type1),
    .pl_addr   (pl_addr),
    .pl_sel    (pl_sel),
    .pl_data0  (pl_data0),
    .pl_data1  (pl_data1),
    .done      (done),
    .abort     (abort),
    .seq_num   (seq_num),
    .TX_DATA   (TX_DATA),
    .TXCTRL    (TXCTRL)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (TX_DATA == K_IDLE && TXCTRL == CTRL_K) k_run++;
  endtask

  task automatic wait_hdr(output int lat, output int gap);
    bit ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      lat++;
      if (TX_DATA == HDR0 && TXCTRL == CTRL_D) ok = 1'b1;
    end
    gap   = k_run;
    k_run = 0;
    check_eq("hdr_found", 32'(ok), 32'd1);
  endtask

  task automatic get_frame(output int lat, output int gap);
    wait_hdr(lat, gap);
    fw[0]   = TX_DATA;
    ctrl_ok = 1'b1;
    done_or = done;
    for (int k = 1; k < FW; k++) begin
      tick();
      fw[k] = TX_DATA;
      if (TXCTRL !== CTRL_D) ctrl_ok = 1'b0;
      done_or |= done;
    end
    tick();
    done_or |= done;
  endtask

  task automatic build_exp(input logic [15:0] seq, input bit port);
    logic [15:0] sum;
    ew[0] = HDR0;
    ew[1] = HDR1;
    ew[2] = seq;
    ew[3] = port ? req_type1 : req_type0;
    ew[4] = 16'(PW);
    sum = ew[2] + ew[3] + ew[4];
    for (int i = 0; i < PW; i++) begin
      ew[5+i] = port ? pay1[i] : pay0[i];
      sum += ew[5+i];
    end
    ew[PW+5] = sum;
    ew[PW+6] = TAIL0;
    ew[PW+7] = TAIL1;
  endtask

  task automatic check_frame(input string tag, input bit port);
    for (int k = 0; k < FW; k++) check_eq($sformatf("%s_w%0d", tag, k), fw[k], ew[k]);
    check_eq({tag, "_ctrl"}, 32'(ctrl_ok), 32'd1);
    check_eq({tag, "_done"}, done_or, port ? 32'd2 : 32'd1);
  endtask

  int lat, gap;
  int exp_port [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    rst = 1'b1; link_up = 1'b1; req = 2'b00;
    req_type0 = TYPE_ACK; req_type1 = TYPE_CFG;
    for (int i = 0; i < 32; i++) begin
      pay0[i] = 16'hA000 + 16'(i);
      pay1[i] = 16'h0000;
    end
    pay1[0] = 16'h0021; pay1[2] = 16'h0010; pay1[4] = 16'h0012;
    pay1[5] = 16'h0010; pay1[6] = 16'h0001; pay1[9] = 16'h0018;
    exp_seq = 16'h0000;

    // 1: reset state and idle K stream
    repeat (3) tick();
    check_eq("rst_tx", TX_DATA, K_IDLE);
    check_eq("rst_ctrl", TXCTRL, CTRL_K);
    check_eq("rst_done", done, 0);
    check_eq("rst_abort", abort, 0);
    check_eq("rst_seq", seq_num, 0);
    check_eq("rst_pl_addr", pl_addr, 0);
    check_eq("rst_pl_sel", pl_sel, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("idle_tx", TX_DATA, K_IDLE);
      check_eq("idle_ctrl", TXCTRL, CTRL_K);
      check_eq("idle_done", done, 0);
    end

    // 2: single port-1 frame with known checksum
    req = 2'b10;
    get_frame(lat, gap);
    check_eq("latency", 32'(lat - 1), 32'(PRE + 1));
    build_exp(16'h0000, 1'b1);
    check_frame("p1", 1'b1);
    check_eq("p1_len", fw[4], 16'h0018);
    check_eq("p1_csum", fw[PW+5], 16'h0085);
    check_eq("p1_pl_sel", pl_sel, 1);
    req = 2'b00;
    tick(); tick();
    exp_seq = 16'h0001;
    check_eq("p1_seq_after", seq_num, exp_seq);

    // 3: both ports requesting continuously
    req_type1 = TYPE_DATA;
    req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      get_frame(lat, gap);
      build_exp(exp_seq, exp_port[i][0]);
      check_frame($sformatf("arb%0d", i), exp_port[i][0]);
      check_eq($sformatf("arb%0d_grant", i), 32'(fw[3] == TYPE_DATA), 32'(exp_port[i]));
      if (i > 0) check_eq($sformatf("arb%0d_gap_ge4", i), 32'(gap >= 4), 32'd1);
      exp_seq++;
    end
    req = 2'b00;
    repeat (10) tick();
    check_eq("arb_seq_after", seq_num, exp_seq);

    // 4: link loss at payload index 10, then full retry
    req = 2'b01;
    wait_hdr(lat, gap);
    repeat (14) tick();
    check_eq("drop_w14", TX_DATA, pay0[9]);
    link_up = 1'b0;
    tick();
    check_eq("drop_tx", TX_DATA, K_IDLE);
    check_eq("drop_ctrl", TXCTRL, CTRL_K);
    check_eq("drop_abort", abort, 1);
    check_eq("drop_seq", seq_num, exp_seq);
    check_eq("drop_done", done, 0);
    tick();
    check_eq("drop_abort_end", abort, 0);
    check_eq("drop_done2", done, 0);
    link_up = 1'b1;
    get_frame(lat, gap);
    build_exp(exp_seq, 1'b0);
    check_frame("retry", 1'b0);
    exp_seq++;
    req = 2'b00;
    repeat (8) tick();

    // 5: sequence wrap FFFF -> 0000
    force dut.seq_q = 16'hFFFF;
    tick(); tick();
    release dut.seq_q;
    exp_seq = 16'hFFFF;
    req = 2'b01;
    for (int i = 0; i < 2; i++) begin
      get_frame(lat, gap);
      build_exp(exp_seq, 1'b0);
      check_frame($sformatf("wrap%0d", i), 1'b0);
      exp_seq++;
    end
    req = 2'b00;
    repeat (8) tick();
    check_eq("wrap_seq_after", seq_num, exp_seq);

    // 6: reset during payload
    req = 2'b01;
    wait_hdr(lat, gap);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check_eq("mrst_tx", TX_DATA, K_IDLE);
    check_eq("mrst_ctrl", TXCTRL, CTRL_K);
    check_eq("mrst_seq", seq_num, 0);
    check_eq("mrst_done", done, 0);
    check_eq("mrst_pl_addr", pl_addr, 0);
    req = 2'b00;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check_eq("mrst_idle_tx", TX_DATA, K_IDLE);
    check_eq("mrst_idle_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
